alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential front end that drives the 32-bit combinational ALU: it accepts one operation request per handshake from the control unit, presents the operands and opcode to the ALU, holds them stable for a programmable settle window, and captures the ALU result into a registered response with status flags. It sits between the processor control unit (request/response side) and the combinational ALU (op1/op2/oprn/result side), and serialises ALU use to one outstanding operation.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPRN_WIDTH, 6, ALU opcode width
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture (legal range 1..15)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_oprn  in  OPRN_WIDTH  opcode: 0x01 add, 0x02 sub, 0x03 mul, 0x04 shr, 0x05 shl, 0x06 and, 0x07 or, 0x08 nor, 0x09 slt
- req_op1, req_op2  in  DATA_WIDTH  operands
- alu_op1, alu_op2  out  DATA_WIDTH  registered operands to ALU
- alu_oprn  out  OPRN_WIDTH  registered opcode to ALU
- alu_result  in  DATA_WIDTH  ALU combinational result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_result  out  DATA_WIDTH  captured result
- rsp_zero  out  1  rsp_result == 0 and rsp_err == 0
- rsp_err  out  1  opcode was outside 0x01..0x09
- op_count  out  16  completed-response counter

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- IDLE: req_ready=1. On edge with req_valid=1: latch req_op1/req_op2/req_oprn into alu_op1/alu_op2/alu_oprn, load settle counter with SETTLE_CYCLES-1, latch err = (req_oprn==0 or req_oprn>0x09), go DRIVE. req_valid=0: stay.
- DRIVE: req_ready=0. Counter decrements each edge; on the edge where counter==0: rsp_result <= err ? 0 : alu_result, rsp_err <= err, rsp_zero <= !err && (alu_result==0), go HOLD.
- HOLD: rsp_valid=1, req_ready=0. On edge with rsp_ready=1: op_count increments (wraps 0xFFFF->0x0000), go IDLE. rsp_ready=0: hold all response outputs unchanged.
- alu_op1/alu_op2/alu_oprn change only on request acceptance; they keep last values in HOLD and IDLE.
- Invalid opcode: same path and latency as valid one; ALU output (X from ALU default) never reaches rsp_result.
- slt result is 0x00000001 or 0x00000000 as produced by ALU; block does not reinterpret results.
- req_ready and rsp_valid are decoded from state only (no combinational path from req_valid/rsp_ready).

## Timing
- Reset (RST=0, asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_op1=0, alu_op2=0, alu_oprn=0, op_count=0. Holds until RST returns high; first acceptance on the first rising CLK after release.
- Latency: request accepted at edge E; rsp_valid=1 after edge E+SETTLE_CYCLES.
- Throughput with rsp_ready held 1: one operation every SETTLE_CYCLES+2 cycles.
- Reset asserted in DRIVE or HOLD: operation discarded, no response, op_count not incremented.
- rsp_ready while not in HOLD: ignored.
- SETTLE_CYCLES outside 1..15: unsupported.

## Test plan
- Reset then req add(0x01) op1=5 op2=7, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_valid 1 edge after accept, rsp_result=0x0000000C, rsp_zero=0, rsp_err=0, op_count=1, req_ready high again 2 cycles after accept.
- sub(0x02) 3-5 then nor(0x08) 0,0 then sub 9-9 -> 0xFFFFFFFE; 0xFFFFFFFF; 0x00000000 with rsp_zero=1.
- Opcode 0x0A and 0x00 -> rsp_err=1, rsp_result=0, rsp_zero=0, same latency, op_count increments.
- rsp_ready=0 for 5 cycles in HOLD -> rsp_* stable, req_ready=0, req_valid pulses ignored; release -> single op_count increment.
- SETTLE_CYCLES=3, mul(0x03) 0x10000*0x10 -> alu ports stable 3 cycles, rsp_valid 3 edges after accept, result 0x00100000.
- RST pulsed low mid-DRIVE (asynchronous, between edges) -> outputs at reset values immediately, no response; op_count preset near 0xFFFF by 65535 ops wraps to 0x0000 on next completion.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// ---------------------------------------------------------------------------
// Sequential front end for a 32-bit combinational ALU. The block accepts one
// request at a time from the control unit and registers the operands and
// opcode onto the ALU inputs. It holds those inputs stable for SETTLE_CYCLES
// edges, then captures the ALU result into a registered response. The
// response is held until the consumer takes it.
//
// Ports
//   CLK           clock, rising edge
//   RST           asynchronous reset, active low
//   req_valid     request present
//   req_ready     block can accept a request (IDLE only)
//   req_oprn      opcode (0x01..0x09 legal)
//   req_op1/op2   operands
//   alu_op1/op2   registered operands driven to the ALU
//   alu_oprn      registered opcode driven to the ALU
//   alu_result    combinational ALU result
//   rsp_valid     response available (HOLD only)
//   rsp_ready     consumer takes the response
//   rsp_result    captured result (0 for an illegal opcode)
//   rsp_zero      result is zero and the opcode was legal
//   rsp_err       opcode was outside 0x01..0x09
//   op_count      completed-response counter, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPRN_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OPRN_WIDTH-1:0] req_oprn,
  input  logic [DATA_WIDTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0] req_op2,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // The settle counter starts at SETTLE_CYCLES-1 so that the capture happens
  // exactly SETTLE_CYCLES edges after acceptance.
  localparam logic [3:0]            SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [OPRN_WIDTH-1:0] OPRN_MAX    = OPRN_WIDTH'(9);

  state_e                  state_q,      state_d;
  logic [3:0]              cnt_q,        cnt_d;
  logic                    err_q,        err_d;
  logic [DATA_WIDTH-1:0]   alu_op1_q,    alu_op1_d;
  logic [DATA_WIDTH-1:0]   alu_op2_q,    alu_op2_d;
  logic [OPRN_WIDTH-1:0]   alu_oprn_q,   alu_oprn_d;
  logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic                    rsp_zero_q,   rsp_zero_d;
  logic                    rsp_err_q,    rsp_err_d;
  logic [15:0]             op_count_q,   op_count_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_oprn_d   = alu_oprn_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          alu_op1_d  = req_op1;
          alu_op2_d  = req_op2;
          alu_oprn_d = req_oprn;
          cnt_d      = SETTLE_LOAD;
          err_d      = (req_oprn == '0) || (req_oprn > OPRN_MAX);
          state_d    = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt_q == 4'd0) begin
          // An illegal opcode leaves the ALU on its default branch. Its output
          // is meaningless, so it is masked here and never reaches the response.
          rsp_result_d = err_q ? '0 : alu_result;
          rsp_err_d    = err_q;
          rsp_zero_d   = !err_q && (alu_result == '0);
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      HOLD: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: state registers use non-blocking assignments so that all flops
    // sample their _d values from the same pre-edge snapshot.
    if (!RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_oprn_q   <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_oprn_q   <= alu_oprn_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  // Handshake outputs come from the state register only. This keeps
  // req_valid and rsp_ready off any combinational path to an output.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == HOLD);
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_oprn   = alu_oprn_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl. Two instances share the clock, reset
// and request data: dut_a uses SETTLE_CYCLES=1 and dut_b uses
// SETTLE_CYCLES=3. A small behavioural ALU sits on each instance's ALU ports.
module tb_alu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  req_oprn = '0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic        rsp_ready = 1'b0;

  logic        req_valid_a = 1'b0, req_ready_a, rsp_valid_a, rsp_zero_a, rsp_err_a;
  logic [31:0] alu_op1_a, alu_op2_a, alu_result_a, rsp_result_a;
  logic [5:0]  alu_oprn_a;
  logic [15:0] op_count_a;

  logic        req_valid_b = 1'b0, req_ready_b, rsp_valid_b, rsp_zero_b, rsp_err_b;
  logic [31:0] alu_op1_b, alu_op2_b, alu_result_b, rsp_result_b;
  logic [5:0]  alu_oprn_b;
  logic [15:0] op_count_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_count_a = '0;

  always #5 CLK = ~CLK;

  // Behavioural ALU; an illegal opcode returns a marker value that must never
  // appear on rsp_result.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] op);
    case (op)
      6'h01:   return a + b;
      6'h02:   return a - b;
      6'h03:   return a * b;
      6'h04:   return a >> b[4:0];
      6'h05:   return a << b[4:0];
      6'h06:   return a & b;
      6'h07:   return a | b;
      6'h08:   return ~(a | b);
      6'h09:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result_a = alu_model(alu_op1_a, alu_op2_a, alu_oprn_a);
  assign alu_result_b = alu_model(alu_op1_b, alu_op2_b, alu_oprn_b);

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .SETTLE_CYCLES(1)) dut_a (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_oprn(req_oprn),
    .req_op1(req_op1), .req_op2(req_op2),
    .alu_op1(alu_op1_a), .alu_op2(alu_op2_a), .alu_oprn(alu_oprn_a),
    .alu_result(alu_result_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_result(rsp_result_a),
    .rsp_zero(rsp_zero_a), .rsp_err(rsp_err_a), .op_count(op_count_a)
  );

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .SETTLE_CYCLES(3)) dut_b (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_oprn(req_oprn),
    .req_op1(req_op1), .req_op2(req_op2),
    .alu_op1(alu_op1_b), .alu_op2(alu_op2_b), .alu_oprn(alu_oprn_b),
    .alu_result(alu_result_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_result(rsp_result_b),
    .rsp_zero(rsp_zero_b), .rsp_err(rsp_err_b), .op_count(op_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full operation on dut_a with rsp_ready held high. The task is called
  // just after a falling edge and returns just after a falling edge.
  task automatic op_a(input string tag, input logic [5:0] oprn, input logic [31:0] op1,
                      input logic [31:0] op2, input logic [31:0] exp_res,
                      input logic exp_zero, input logic exp_err);
    check({tag, ".ready_in"}, req_ready_a, 1);
    req_oprn    = oprn;
    req_op1     = op1;
    req_op2     = op2;
    req_valid_a = 1'b1;
    rsp_ready   = 1'b1;
    @(negedge CLK);                       // accepted at edge E
    req_valid_a = 1'b0;
    check({tag, ".drive_valid"}, rsp_valid_a, 0);
    check({tag, ".drive_ready"}, req_ready_a, 0);
    check({tag, ".alu_op1"}, alu_op1_a, op1);
    check({tag, ".alu_oprn"}, alu_oprn_a, oprn);
    @(negedge CLK);                       // after E+1: HOLD
    check({tag, ".rsp_valid"}, rsp_valid_a, 1);
    check({tag, ".result"}, rsp_result_a, exp_res);
    check({tag, ".zero"}, rsp_zero_a, exp_zero);
    check({tag, ".err"}, rsp_err_a, exp_err);
    @(negedge CLK);                       // after E+2: back in IDLE
    exp_count_a++;
    check({tag, ".ready_again"}, req_ready_a, 1);
    check({tag, ".valid_gone"}, rsp_valid_a, 0);
    check({tag, ".op_count"}, op_count_a, exp_count_a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst.req_ready", req_ready_a, 1);
    check("rst.rsp_valid", rsp_valid_a, 0);
    check("rst.rsp_result", rsp_result_a, 0);
    check("rst.rsp_zero_err", {rsp_zero_a, rsp_err_a}, 0);
    check("rst.alu_ports", alu_op1_a | alu_op2_a | 32'(alu_oprn_a), 0);
    check("rst.op_count", op_count_a, 0);
    @(negedge CLK);
    RST = 1'b1;

    // Basic operations, SETTLE_CYCLES=1
    op_a("add",  6'h01, 32'd5, 32'd7, 32'h0000_000C, 1'b0, 1'b0);
    op_a("sub",  6'h02, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op_a("nor",  6'h08, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op_a("sub0", 6'h02, 32'd9, 32'd9, 32'h0000_0000, 1'b1, 1'b0);
    op_a("slt",  6'h09, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b0, 1'b0);
    op_a("shl",  6'h05, 32'h0000_0003, 32'd4, 32'h0000_0030, 1'b0, 1'b0);

    // Illegal opcodes: same latency, masked result, still counted
    op_a("err0a", 6'h0A, 32'd1, 32'd2, 32'h0000_0000, 1'b0, 1'b1);
    op_a("err00", 6'h00, 32'd0, 32'd0, 32'h0000_0000, 1'b0, 1'b1);

    // Back-pressure in HOLD
    req_oprn = 6'h06; req_op1 = 32'h0000_F0F0; req_op2 = 32'h0000_FF00;
    req_valid_a = 1'b1; rsp_ready = 1'b0;
    @(negedge CLK);
    req_valid_a = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", rsp_valid_a, 1);
      check("bp.result", rsp_result_a, 32'h0000_F000);
      check("bp.ready", req_ready_a, 0);
      check("bp.alu_op1", alu_op1_a, 32'h0000_F0F0);
      check("bp.count", op_count_a, exp_count_a);
      req_valid_a = i[0];
      req_op1     = 32'h1234_5678;
      @(negedge CLK);
    end
    req_valid_a = 1'b0;
    rsp_ready   = 1'b1;
    @(negedge CLK);
    exp_count_a++;
    check("bp.release_count", op_count_a, exp_count_a);
    check("bp.release_valid", rsp_valid_a, 0);
    @(negedge CLK);
    check("bp.single_count", op_count_a, exp_count_a);
    check("bp.no_accept", req_ready_a, 1);

    // SETTLE_CYCLES=3 on dut_b: mul 0x10000 * 0x10
    req_oprn = 6'h03; req_op1 = 32'h0001_0000; req_op2 = 32'h0000_0010;
    req_valid_b = 1'b1;
    @(negedge CLK);                       // accepted at edge E
    req_valid_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mul.not_yet", rsp_valid_b, 0);
      check("mul.alu_op1", alu_op1_b, 32'h0001_0000);
      check("mul.alu_op2", alu_op2_b, 32'h0000_0010);
      check("mul.alu_oprn", alu_oprn_b, 6'h03);
      req_op1 = 32'hAAAA_5555;
      @(negedge CLK);
    end
    check("mul.valid", rsp_valid_b, 1);
    check("mul.result", rsp_result_b, 32'h0010_0000);
    @(negedge CLK);
    check("mul.count", op_count_b, 1);

    // Asynchronous reset in the middle of DRIVE on dut_b
    req_oprn = 6'h01; req_op1 = 32'd1; req_op2 = 32'd1;
    req_valid_b = 1'b1;
    @(negedge CLK);
    req_valid_b = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("arst.ready", req_ready_b, 1);
    check("arst.valid", rsp_valid_b, 0);
    check("arst.alu_op1", alu_op1_b, 0);
    check("arst.count_b", op_count_b, 0);
    check("arst.count_a", op_count_a, 0);
    exp_count_a = '0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("arst.no_rsp", rsp_valid_b, 0);
    check("arst.no_count", op_count_b, 0);

    // Counter wrap: preset dut_a's counter to 0xFFFF, then complete one op
    force dut_a.op_count_q = 16'hFFFF;
    #1 release dut_a.op_count_q;
    exp_count_a = 16'hFFFF;
    check("wrap.preset", op_count_a, 16'hFFFF);
    op_a("wrap", 6'h07, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
